// File: rtl/flash_read_streamer_if.sv
// Signal bundle between the flash read streamer, its client, the SPI bus arbiter and the
// flash handler. The master modport is the streamer's view; slave is the surrounding logic.
interface flash_read_streamer_if #(
  parameter int unsigned MAX_BYTES = 4096
) ();
  logic                     i_cmd_valid;
  logic [23:0]              i_cmd_addr;
  logic [11:0]              i_cmd_num;
  logic                     o_cmd_ready;
  logic                     o_bus_req;
  logic                     i_bus_grant;
  logic                     o_data_request;
  logic [23:0]              o_read_addr;
  logic [11:0]              o_read_num;
  logic                     i_data_ready;
  logic                     i_command_error;
  logic [8*MAX_BYTES-1:0]   i_data;
  logic [7:0]               o_byte;
  logic                     o_byte_valid;
  logic                     o_byte_last;
  logic                     i_byte_ready;
  logic                     o_done;
  logic                     o_error;

  modport master (
    input  i_cmd_valid, i_cmd_addr, i_cmd_num, i_bus_grant, i_data_ready, i_command_error,
           i_data, i_byte_ready,
    output o_cmd_ready, o_bus_req, o_data_request, o_read_addr, o_read_num, o_byte,
           o_byte_valid, o_byte_last, o_done, o_error
  );

  modport slave (
    output i_cmd_valid, i_cmd_addr, i_cmd_num, i_bus_grant, i_data_ready, i_command_error,
           i_data, i_byte_ready,
    input  o_cmd_ready, o_bus_req, o_data_request, o_read_addr, o_read_num, o_byte,
           o_byte_valid, o_byte_last, o_done, o_error
  );
endinterface

// File: rtl/flash_read_streamer.sv
// Accepts a flash read command, arbitrates for the SPI bus, drives the handler handshake and
// replays the handler's wide data bus to the client one byte per valid/ready handshake.
module flash_read_streamer #(
  parameter int unsigned MAX_BYTES = 4096
) (
  input logic                  i_sys_clk,
  input logic                  i_reset,
  flash_read_streamer_if.master bus
);

  localparam int unsigned SelW = $clog2(8 * MAX_BYTES);

  typedef enum logic [2:0] {StIdle, StGrant, StReq, StRelease, StStream} state_e;

  state_e                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   bus_req_q, bus_req_d;
  logic                   data_request_q, data_request_d;
  logic [23:0]            read_addr_q, read_addr_d;
  logic [11:0]            read_num_q, read_num_d;
  logic [7:0]             byte_q, byte_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   byte_last_q, byte_last_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [11:0]            idx_q, idx_d;
  logic [8*MAX_BYTES-1:0] buf_q;
  logic                   buf_we;
  logic [SelW-1:0]        byte_sel;

  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    bus_req_d      = bus_req_q;
    data_request_d = data_request_q;
    read_addr_d    = read_addr_q;
    read_num_d     = read_num_q;
    byte_d         = byte_q;
    byte_valid_d   = byte_valid_q;
    byte_last_d    = byte_last_q;
    idx_d          = idx_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    buf_we         = 1'b0;
    byte_sel       = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_cmd_valid && cmd_ready_q) begin
          read_addr_d = bus.i_cmd_addr;
          read_num_d  = bus.i_cmd_num;
          if (bus.i_cmd_num == 12'd0) begin
            error_d = 1'b1;
          end else begin
            state_d     = StGrant;
            bus_req_d   = 1'b1;
            cmd_ready_d = 1'b0;
          end
        end
      end
      StGrant: begin
        if (bus.i_bus_grant) begin
          data_request_d = 1'b1;
          state_d        = StReq;
        end
      end
      StReq: begin
        // A handler error wins over a simultaneous data_ready.
        if (bus.i_command_error) begin
          data_request_d = 1'b0;
          bus_req_d      = 1'b0;
          error_d        = 1'b1;
          cmd_ready_d    = 1'b1;
          state_d        = StIdle;
        end else if (bus.i_data_ready) begin
          buf_we         = 1'b1;
          data_request_d = 1'b0;
          state_d        = StRelease;
        end
      end
      StRelease: begin
        if (!bus.i_data_ready) begin
          bus_req_d    = 1'b0;
          idx_d        = '0;
          byte_d       = buf_q[7:0];
          byte_valid_d = 1'b1;
          byte_last_d  = (read_num_q == 12'd1);
          state_d      = StStream;
        end
      end
      StStream: begin
        if (bus.i_byte_ready) begin
          if (byte_last_q) begin
            byte_d       = '0;
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
            done_d       = 1'b1;
            cmd_ready_d  = 1'b1;
            state_d      = StIdle;
          end else begin
            // Output is registered, so preload the byte for the next index.
            idx_d       = idx_q + 12'd1;
            byte_sel    = SelW'({idx_d, 3'b000});
            byte_d      = buf_q[byte_sel +: 8];
            byte_last_d = (idx_d == read_num_q - 12'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= StIdle;
      cmd_ready_q    <= 1'b1;
      bus_req_q      <= 1'b0;
      data_request_q <= 1'b0;
      read_addr_q    <= '0;
      read_num_q     <= '0;
      byte_q         <= '0;
      byte_valid_q   <= 1'b0;
      byte_last_q    <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      idx_q          <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      bus_req_q      <= bus_req_d;
      data_request_q <= data_request_d;
      read_addr_q    <= read_addr_d;
      read_num_q     <= read_num_d;
      byte_q         <= byte_d;
      byte_valid_q   <= byte_valid_d;
      byte_last_q    <= byte_last_d;
      done_q         <= done_d;
      error_q        <= error_d;
      idx_q          <= idx_d;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (buf_we) begin
      buf_q <= bus.i_data;
    end
  end

  assign bus.o_cmd_ready    = cmd_ready_q;
  assign bus.o_bus_req      = bus_req_q;
  assign bus.o_data_request = data_request_q;
  assign bus.o_read_addr    = read_addr_q;
  assign bus.o_read_num     = read_num_q;
  assign bus.o_byte         = byte_q;
  assign bus.o_byte_valid   = byte_valid_q;
  assign bus.o_byte_last    = byte_last_q;
  assign bus.o_done         = done_q;
  assign bus.o_error        = error_q;

endmodule

// File: tb/tb_flash_read_streamer.sv
// Directed bench for flash_read_streamer: a 128 KiB flash model feeds a scripted handler and
// every streamed byte, handshake and pulse is checked against values computed here.
module tb_flash_read_streamer;

  localparam int unsigned MaxBytes  = 4096;
  localparam int unsigned FlashSize = 32'h20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  flash_read_streamer_if #(.MAX_BYTES(MaxBytes)) bus ();

  flash_read_streamer #(.MAX_BYTES(MaxBytes)) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fbyte(input int unsigned a);
    int unsigned w;
    w = a % FlashSize;
    return 8'((w * 32'd131) ^ (w >> 9) ^ 32'hA5);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":cmd_ready"}, bus.o_cmd_ready, 1);
    check({tag, ":bus_req"}, bus.o_bus_req, 0);
    check({tag, ":data_request"}, bus.o_data_request, 0);
    check({tag, ":read_addr"}, bus.o_read_addr, 0);
    check({tag, ":read_num"}, bus.o_read_num, 0);
    check({tag, ":byte"}, bus.o_byte, 0);
    check({tag, ":byte_valid"}, bus.o_byte_valid, 0);
    check({tag, ":byte_last"}, bus.o_byte_last, 0);
    check({tag, ":done"}, bus.o_done, 0);
    check({tag, ":error"}, bus.o_error, 0);
  endtask

  // Returns at the negedge just after the accept edge.
  task automatic send_cmd(input logic [23:0] a, input logic [11:0] n);
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = a;
    bus.i_cmd_num   = n;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic load_data(input int unsigned a, input int unsigned n);
    for (int k = 0; k < MaxBytes; k++) begin
      bus.i_data[8*k +: 8] = (k < n) ? fbyte(a + k) : 8'h00;
    end
  endtask

  task automatic run_read(input logic [23:0] a, input int n, input int gdelay, input bit bp,
                          input int rst_at, input string tag);
    int         idx;
    int         cyc;
    logic [7:0] lfsr;
    logic       rdy;
    logic       stalled;
    logic [7:0] prev_byte;
    idx       = 0;
    cyc       = 0;
    lfsr      = 8'hA5;
    stalled   = 1'b0;
    prev_byte = '0;

    send_cmd(a, 12'(n));
    check({tag, ":bus_req_after_accept"}, bus.o_bus_req, 1);
    check({tag, ":cmd_ready_busy"}, bus.o_cmd_ready, 0);
    check({tag, ":read_addr"}, bus.o_read_addr, 64'(a));
    check({tag, ":read_num"}, bus.o_read_num, 64'(n));
    check({tag, ":data_request_pre_grant"}, bus.o_data_request, 0);
    repeat (gdelay) @(negedge clk);
    check({tag, ":data_request_still_low"}, bus.o_data_request, 0);
    bus.i_bus_grant = 1'b1;
    @(negedge clk);
    check({tag, ":data_request_after_grant"}, bus.o_data_request, 1);
    load_data(a, n);
    @(negedge clk);
    check({tag, ":data_request_held"}, bus.o_data_request, 1);
    bus.i_data_ready = 1'b1;
    @(negedge clk);
    check({tag, ":data_request_drop"}, bus.o_data_request, 0);
    check({tag, ":bus_req_in_release"}, bus.o_bus_req, 1);
    @(negedge clk);
    check({tag, ":no_valid_in_release"}, bus.o_byte_valid, 0);
    bus.i_data_ready = 1'b0;
    bus.i_bus_grant  = 1'b0;
    @(negedge clk);

    while (idx < n && cyc < 4 * n + 50) begin
      if (rst_at >= 0 && idx == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_values({tag, ":async_reset"});
        @(negedge clk);
        rst = 1'b0;
        bus.i_byte_ready = 1'b0;
        return;
      end
      rdy = bp ? lfsr[0] : 1'b1;
      bus.i_byte_ready = rdy;
      check($sformatf("%s:valid[%0d]", tag, idx), bus.o_byte_valid, 1);
      check($sformatf("%s:byte[%0d]", tag, idx), bus.o_byte, 64'(fbyte(a + idx)));
      check($sformatf("%s:last[%0d]", tag, idx), bus.o_byte_last, 64'(idx == n - 1));
      check($sformatf("%s:bus_req_stream[%0d]", tag, idx), bus.o_bus_req, 0);
      check($sformatf("%s:done_early[%0d]", tag, idx), bus.o_done, 0);
      if (stalled) check($sformatf("%s:stall_hold[%0d]", tag, idx), bus.o_byte, 64'(prev_byte));
      stalled   = !rdy;
      prev_byte = bus.o_byte;
      if (rdy) idx++;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      @(negedge clk);
      cyc++;
    end
    check({tag, ":stream_complete"}, 64'(idx), 64'(n));
    bus.i_byte_ready = 1'b0;
    check({tag, ":done_pulse"}, bus.o_done, 1);
    check({tag, ":cmd_ready_with_done"}, bus.o_cmd_ready, 1);
    check({tag, ":valid_after_done"}, bus.o_byte_valid, 0);
    @(negedge clk);
    check({tag, ":done_one_cycle"}, bus.o_done, 0);
  endtask

  task automatic err_read(input logic [23:0] a, input bit with_ready, input string tag);
    send_cmd(a, 12'd8);
    bus.i_bus_grant = 1'b1;
    @(negedge clk);
    check({tag, ":data_request"}, bus.o_data_request, 1);
    bus.i_command_error = 1'b1;
    bus.i_data_ready    = with_ready;
    @(negedge clk);
    bus.i_command_error = 1'b0;
    bus.i_data_ready    = 1'b0;
    bus.i_bus_grant     = 1'b0;
    check({tag, ":error_pulse"}, bus.o_error, 1);
    check({tag, ":bus_req_drop"}, bus.o_bus_req, 0);
    check({tag, ":data_request_drop"}, bus.o_data_request, 0);
    check({tag, ":no_valid"}, bus.o_byte_valid, 0);
    check({tag, ":cmd_ready_idle"}, bus.o_cmd_ready, 1);
    repeat (2) @(negedge clk);
    check({tag, ":error_cleared"}, bus.o_error, 0);
    check({tag, ":still_no_valid"}, bus.o_byte_valid, 0);
    check({tag, ":bus_req_low"}, bus.o_bus_req, 0);
  endtask

  initial begin
    bus.i_cmd_valid     = 1'b0;
    bus.i_cmd_addr      = '0;
    bus.i_cmd_num       = '0;
    bus.i_bus_grant     = 1'b0;
    bus.i_data_ready    = 1'b0;
    bus.i_command_error = 1'b0;
    bus.i_data          = '0;
    bus.i_byte_ready    = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", bus.o_cmd_ready, 1);

    run_read(24'h000005, 16, 3, 1'b0, -1, "basic");
    run_read(24'h01FFFC, 16, 1, 1'b1, -1, "backpressure");
    run_read(24'h000000, 2112, 2, 1'b0, -1, "full");

    send_cmd(24'h000123, 12'd0);
    check("zero:error_pulse", bus.o_error, 1);
    check("zero:bus_req", bus.o_bus_req, 0);
    check("zero:data_request", bus.o_data_request, 0);
    check("zero:cmd_ready", bus.o_cmd_ready, 1);
    @(negedge clk);
    check("zero:error_one_cycle", bus.o_error, 0);
    check("zero:bus_req_later", bus.o_bus_req, 0);
    check("zero:data_request_later", bus.o_data_request, 0);

    err_read(24'h000040, 1'b0, "herr");
    err_read(24'h000080, 1'b1, "herr_with_ready");

    run_read(24'h000300, 24, 1, 1'b0, 7, "midreset");
    run_read(24'h000000, 8, 1, 1'b0, -1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
